// File: rtl/fifo_tx_serializer.sv
// Pops one word at a time from a show-ahead-less FIFO and sends it as a UART-style
// frame: start bit (0), WIDTH data bits LSB-first, stop bit (1), each BAUD_DIV clocks.
module fifo_tx_serializer #(
  parameter int WIDTH    = 8,
  parameter int BAUD_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_ren,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic [15:0]      frame_cnt
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             tx_q, tx_d;
  logic             ren_q, ren_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             baud_end;

  assign baud_end = (baud_q == BW'(BAUD_DIV - 1));

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (en && !fifo_empty) state_d = POP;
      POP:  state_d = LOAD;
      // Read data is valid the cycle after the strobe, i.e. during LOAD.
      LOAD: begin
        shift_d = fifo_rdata;
        baud_d  = '0;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + CW'(1);
          if (bit_q == CW'(WIDTH - 1)) begin
            bit_d   = '0;
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d      = '0;
          state_d     = IDLE;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    ren_d  = (state_d == POP);
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      baud_q      <= '0;
      bit_q       <= '0;
      frame_cnt_q <= '0;
      tx_q        <= 1'b1;
      ren_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      frame_cnt_q <= frame_cnt_d;
      tx_q        <= tx_d;
      ren_q       <= ren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign fifo_ren  = ren_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Bench for fifo_tx_serializer: a FIFO model feeds words, a monitor decodes every
// frame on tx and checks it against the queue of words the FIFO handed out.
module tb_fifo_tx_serializer;
  localparam int WIDTH = 8;
  localparam int BAUD  = 4;
  localparam int FRAME_CYC = (WIDTH + 2) * BAUD;

  logic             clk = 1'b0;
  logic             reset, en, fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_ren, tx, busy, done;
  logic [15:0]      frame_cnt;

  fifo_tx_serializer #(.WIDTH(WIDTH), .BAUD_DIV(BAUD)) dut (
    .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren), .tx(tx), .busy(busy),
    .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- FIFO model ----------------
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] pop_w;
  logic             ren_n = 1'b0;
  int               ren_count = 0;
  int               pop_cyc = 0;

  task automatic push(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  always @(negedge clk) begin
    ren_n = fifo_ren;
    if (fifo_ren === 1'b1) begin
      ren_count++;
      pop_cyc = cyc;
      chk("ren_nonempty", 32'(fifo_q.size() != 0), 1);
    end
  end

  always @(posedge clk) begin
    #1;
    if (ren_n === 1'b1 && fifo_q.size() != 0) begin
      pop_w      = fifo_q.pop_front();
      fifo_rdata = pop_w;
      exp_q.push_back(pop_w);
    end else begin
      fifo_rdata = WIDTH'($urandom);
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // ---------------- Monitor ----------------
  bit               mon_active = 1'b0;
  bit               mon_pend = 1'b0;
  int               mon_k = 0;
  int               glitch = 0;
  int               idle_cnt = 0;
  int               last_gap = 0;
  int               frames_done = 0;
  logic [15:0]      mon_cnt = '0;
  logic [WIDTH+1:0] rx, exp_frame, last_frame;
  logic [WIDTH-1:0] mon_w;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      mon_active = 1'b0;
      mon_pend   = 1'b0;
      mon_cnt    = '0;
      idle_cnt   = 0;
    end else begin
      if (mon_pend) begin
        mon_cnt = mon_cnt + 16'd1;
        chk("done_pulse", 32'(done), 1);
        chk("frame_cnt_at_done", 32'(frame_cnt), 32'(mon_cnt));
        mon_pend = 1'b0;
      end else if (done !== 1'b0) begin
        chk("done_spurious", 32'(done), 0);
      end
      if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          mon_k      = 0;
          glitch     = 0;
          rx         = '0;
          last_gap   = idle_cnt;
          if (exp_q.size() == 0) begin
            chk("frame_expected", 0, 1);
            exp_frame = '1;
          end else begin
            mon_w     = exp_q.pop_front();
            exp_frame = {1'b1, mon_w, 1'b0};
          end
          chk("start_latency", 32'(cyc - pop_cyc), 2);
        end else begin
          idle_cnt++;
        end
      end
      if (mon_active) begin
        if (tx !== exp_frame[mon_k / BAUD]) glitch++;
        if (mon_k % BAUD == BAUD / 2) rx[mon_k / BAUD] = tx;
        if (mon_k == FRAME_CYC - 1) begin
          chk("frame_bits", 32'(rx), 32'(exp_frame));
          chk("frame_timing", 32'(glitch), 0);
          last_frame  = rx;
          frames_done++;
          mon_active  = 1'b0;
          mon_pend    = 1'b1;
          idle_cnt    = 0;
        end else begin
          mon_k++;
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic wait_frames(input int n, input int budget);
    int t;
    int target;
    t = 0;
    target = frames_done + n;
    while (frames_done < target && t < budget) begin
      step(1);
      t++;
    end
    chk("wait_frames", 32'(frames_done >= target), 1);
    step(1);
  endtask

  task automatic wait_k(input int k, input int budget);
    int t;
    t = 0;
    while (!(mon_active && mon_k == k) && t < budget) begin
      step(1);
      t++;
    end
    chk("wait_bit", 32'(mon_active && mon_k == k), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ren", 32'(fifo_ren), 0);
    chk("rst_cnt", 32'(frame_cnt), 0);
    reset = 1'b0;
  endtask

  int base;

  initial begin
    reset      = 1'b1;
    en         = 1'b0;
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    do_reset();

    // Single word 0xA5.
    push(8'hA5);
    en = 1'b1;
    wait_frames(1, 200);
    chk("a5_frame", 32'(last_frame), 32'h34A);
    chk("a5_cnt", 32'(frame_cnt), 1);
    chk("a5_ren_pulses", 32'(ren_count), 1);

    // Back-to-back 0x00 then 0xFF.
    do_reset();
    push(8'h00);
    push(8'hFF);
    wait_frames(2, 300);
    chk("ff_frame", 32'(last_frame), 32'h3FE);
    chk("b2b_gap", 32'(last_gap), 3);
    chk("b2b_cnt", 32'(frame_cnt), 2);

    // en held low with data present.
    en = 1'b0;
    push(8'h5A);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("hold_ren", 32'(fifo_ren), 0);
      chk("hold_tx", 32'(tx), 1);
      chk("hold_busy", 32'(busy), 0);
    end
    en = 1'b1;
    step(1);
    chk("en_pop_ren", 32'(fifo_ren), 1);
    chk("en_pop_busy", 32'(busy), 1);
    wait_frames(1, 200);

    // en dropped during data bit 3.
    push(8'h3C);
    push(8'h81);
    wait_k(17, 200);
    en = 1'b0;
    wait_frames(1, 200);
    base = ren_count;
    step(30);
    chk("en_off_no_ren", 32'(ren_count), 32'(base));
    chk("en_off_busy", 32'(busy), 0);
    chk("en_off_cnt", 32'(frame_cnt), 4);
    en = 1'b1;
    wait_frames(1, 200);
    chk("w81_frame", 32'(last_frame), 32'h302);
    chk("w81_cnt", 32'(frame_cnt), 5);

    // Reset during data bit 5.
    push(8'h77);
    wait_k(25, 200);
    reset = 1'b1;
    push(8'h11);
    step(1);
    chk("midrst_tx", 32'(tx), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_cnt", 32'(frame_cnt), 0);
    for (int i = 0; i < 4; i++) begin
      chk("midrst_ren", 32'(fifo_ren), 0);
      step(1);
    end
    reset = 1'b0;
    wait_frames(1, 200);
    chk("w11_frame", 32'(last_frame), 32'h222);
    chk("w11_cnt", 32'(frame_cnt), 1);

    // frame_cnt wrap.
    en = 1'b0;
    step(2);
    force dut.frame_cnt_q = 16'hFFFF;
    mon_cnt = 16'hFFFF;
    step(2);
    release dut.frame_cnt_q;
    step(1);
    chk("preset_cnt", 32'(frame_cnt), 32'hFFFF);
    push(8'h96);
    en = 1'b1;
    wait_frames(1, 200);
    chk("wrap_cnt", 32'(frame_cnt), 0);
    chk("w96_frame", 32'(last_frame), 32'h32C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_tx_serializer.md
FIFO_TX_SERIALIZER -- requirements
Module: fifo_tx_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the bits per FIFO word and per frame payload.
REQ-002 The block SHALL have parameter BAUD_DIV, default 4, setting the clocks per serial bit, legal range 2..255.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the synchronous active-high reset, sampled on the clk rising edge.
REQ-005 Port en, input, 1, SHALL enable starting new frames.
REQ-006 Port fifo_empty, input, 1, SHALL be the source FIFO's empty flag (1 = no data).
REQ-007 Port fifo_rdata, input, WIDTH, SHALL be the source FIFO's read data, valid the cycle after fifo_ren is high.
REQ-008 Port fifo_ren, output, 1, SHALL be the FIFO read strobe, registered.
REQ-009 Port tx, output, 1, SHALL be the serial line, idle high, registered.
REQ-010 Port busy, output, 1, SHALL be high in every state except IDLE.
REQ-011 Port done, output, 1, SHALL be a one-cycle pulse per completed frame.
REQ-012 Port frame_cnt, output, 16, SHALL count completed frames.

Function
REQ-013 FSM states SHALL be IDLE, POP, LOAD, START, DATA and STOP.
REQ-014 IDLE with en=1 and fifo_empty=0 SHALL go to POP; otherwise it SHALL stay in IDLE.
REQ-015 fifo_ren SHALL be 1 only during the single POP cycle; POP SHALL always go to LOAD.
REQ-016 At the end of LOAD, fifo_rdata SHALL be captured into the shift register, the bit and baud counters cleared, and the FSM SHALL go to START.
REQ-017 START SHALL drive tx=0 for BAUD_DIV cycles; first START cycle = POP cycle + 2.
REQ-018 DATA SHALL drive WIDTH payload bits LSB-first, each for exactly BAUD_DIV cycles; the bit counter SHALL advance when the baud counter reaches BAUD_DIV-1.
REQ-019 STOP SHALL drive tx=1 for BAUD_DIV cycles, then go to IDLE.
REQ-020 Frame length on tx SHALL be (WIDTH+2)*BAUD_DIV cycles.
REQ-021 done SHALL be 1 in the first IDLE cycle after STOP, and frame_cnt SHALL increment by 1 in that same cycle, wrapping 0xFFFF -> 0x0000.
REQ-022 In IDLE, POP and LOAD, tx SHALL be 1.
REQ-023 Back-to-back words SHALL give exactly 3 tx-high cycles (IDLE, POP, LOAD) between the last STOP cycle and the next START.
REQ-024 en deasserted after POP SHALL NOT abort the frame in progress; it only blocks the next IDLE->POP.
REQ-025 fifo_empty and fifo_rdata SHALL be ignored outside the IDLE decision and the LOAD capture.
REQ-026 At most one fifo_ren pulse SHALL occur per frame; fifo_ren SHALL never be high while fifo_empty was 1 at the IDLE decision.

Reset
REQ-027 reset=1 SHALL, at the next clk edge, force: state IDLE, tx=1, fifo_ren=0, busy=0, done=0, frame_cnt=0, shift register and counters 0.
REQ-028 Reset mid-frame SHALL discard the word in flight without a done pulse; the next frame SHALL start only after reset is released and the IDLE condition holds.
REQ-029 reset SHALL take priority over all other inputs.

Verification (WIDTH=8, BAUD_DIV=4)
REQ-030 FIFO holds 0xA5, en=1 -> one fifo_ren pulse; tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles); done once; frame_cnt=1.
REQ-031 FIFO holds 0x00 then 0xFF -> both frames sent, payloads all-0 then all-1; 3 idle-high cycles between them; frame_cnt=2.
REQ-032 en=0 with fifo_empty=0 for 20 cycles -> fifo_ren never 1, tx=1, busy=0; en=1 -> POP on the next edge.
REQ-033 en dropped in DATA bit 3 -> frame completes; no further fifo_ren while en=0.
REQ-034 reset asserted in DATA bit 5 -> next cycle tx=1, busy=0, done=0, frame_cnt=0; no fifo_ren while reset=1.
REQ-035 frame_cnt preset near wrap (0xFFFF) via 65536 frames or force -> increments to 0x0000 on the next done.
